// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/readout bundle between the front panel and the stopwatch sequencer.
// The master drives the command pulses and observes the count outputs.
interface bcd_stopwatch_ctrl_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic [15:0] q;
    logic [15:0] lap_q;
    logic        lap_valid;
    logic        tick;
    logic        running;
    logic        done;

    modport master (
        output start, stop, clear, lap,
        input  q, lap_q, lap_valid, tick, running, done
    );

    modport slave (
        input  start, stop, clear, lap,
        output q, lap_q, lap_valid, tick, running, done
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear sequencer for a 4-digit packed-BCD stopwatch.
// Contains the prescaler, the control FSM, the BCD digit chain and lap capture.
module bcd_stopwatch_ctrl #(
    parameter int          PRESCALE = 10,
    parameter logic [15:0] MAX_BCD  = 16'h9999
) (
    input  logic                   clk,
    input  logic                   reset,
    bcd_stopwatch_ctrl_if.slave    bus
);
    localparam int          PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc;
    logic [15:0]   q, q_inc, lap_q;
    logic          lap_valid;
    logic          tick;
    logic          carry;

    // Ripple BCD increment: each digit at 9 wraps to 0 and passes the carry on.
    always_comb begin
        q_inc = q;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (q[i*4 +: 4] == 4'd9) begin
                    q_inc[i*4 +: 4] = 4'd0;
                end else begin
                    q_inc[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (bus.start) state_nx = RUN;
                RUN: begin
                    if (bus.stop)                   state_nx = PAUSE;
                    else if (tick && q_inc == MAX_BCD) state_nx = DONE;
                end
                PAUSE: if (!bus.stop && bus.start) state_nx = RUN;
                DONE:  state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        tick        = (state == RUN) && (presc == LAST) && !bus.stop && !bus.clear;
        bus.tick    = tick;
        bus.running = (state == RUN);
        bus.done    = (state == DONE);
    end

    // Lap samples q before this cycle's increment, so it reads the pre-tick count.
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            presc     <= '0;
            lap_q     <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= 1'b0;
            if (bus.clear) begin
                q     <= '0;
                presc <= '0;
            end else begin
                if (state == RUN && !bus.stop)
                    presc <= (presc == LAST) ? '0 : presc + PW'(1);
                if (tick)
                    q <= q_inc;
                if (bus.lap && (state == RUN || state == PAUSE)) begin
                    lap_q     <= q;
                    lap_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.q         = q;
    assign bus.lap_q     = lap_q;
    assign bus.lap_valid = lap_valid;
endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Run/pause/clear sequencer for a 4-digit BCD time counter. It owns a prescaler, a four-state control FSM and the enable-gated BCD digit chain (ones, tens, hundreds, thousands). It sits between the front-panel command pulses and the display/readout logic. It gates counting on a prescaled tick, stops at a programmable terminal value, and captures lap snapshots.

## Interface
- PRESCALE, 10: clk cycles per count step; legal range ≥1.
- MAX_BCD, 16'h9999: terminal count; must be valid nonzero packed BCD.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  start/resume command, sampled every cycle
- stop  input  1  pause command
- clear  input  1  return to zero/idle
- lap  input  1  capture current count
- q  output  16  packed BCD count {thousands, hundreds, tens, ones}, registered
- lap_q  output  16  last captured count, registered
- lap_valid  output  1  one-cycle pulse when lap_q updates
- tick  output  1  combinational; high in the cycle an increment is committed
- running  output  1  state == RUN
- done  output  1  state == DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE. Command priority each cycle: clear > stop > start. lap is independent of these.
- IDLE: q = 0, prescaler = 0. start → RUN. stop is ignored.
- RUN: prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (presc == PRESCALE-1) && !stop && !clear.
  - On tick, q advances by one in BCD. A digit at 9 goes to 0 and carries into the next digit.
  - If the incremented value equals MAX_BCD, next state is DONE.
  - stop → PAUSE. In that cycle, prescaler and q hold with no tick.
- PAUSE: prescaler and q hold. start → RUN, resuming from the held prescaler value (no restart of the partial period).
- DONE: q holds MAX_BCD and tick = 0. start and stop are ignored. Only clear exits.
- clear, from any state: next state IDLE; q, prescaler ← 0; lap_valid ← 0. lap_q is retained.
- lap, in RUN or PAUSE without clear: lap_q ← q as it stood before any increment in that cycle; lap_valid = 1 the next cycle only. lap is ignored in IDLE and DONE.
- No wrap past MAX_BCD. With MAX_BCD = 16'h9999, the 9999 → 0000 rollover never occurs.
- Prescaler width is max(1, clog2(PRESCALE)). With PRESCALE = 1, tick fires every RUN cycle that has no stop/clear.

## Timing
- Reset values: state IDLE, q = 16'h0000, lap_q = 16'h0000, lap_valid = 0, running = 0, done = 0, tick = 0, prescaler = 0.
- Reset overrides all commands, including mid-RUN.
- start sampled at edge t: running = 1 from t+1. First tick occurs in cycle t+PRESCALE; q = 0001 is visible from edge t+PRESCALE+1.
- The final increment to MAX_BCD and the transition to DONE land on the same edge: done = 1 in the same cycle q first reads MAX_BCD.
- A lap command at edge t gives lap_q / lap_valid valid in cycle t+1.
- Commands are level-sampled. A start held high across RUN has no effect. A stop held high keeps the block in PAUSE, or blocks resume, since stop has priority over start.

## Test plan
- Start latency: PRESCALE=10; reset, then start for 1 cycle → running rises next cycle; q = 16'h0001 exactly 11 cycles after the start edge; tick period is 10 cycles.
- Carry chain: PRESCALE=1, run continuously → q steps 0009→0010, 0099→0100, 0999→1000 with no non-BCD values (no nibble > 9) at any point.
- Pause/resume: PRESCALE=10; stop at prescaler = 4; hold 50 cycles → q unchanged, tick = 0. Then start → next tick 6 cycles after resume (remaining count preserved).
- Terminal: MAX_BCD=16'h0012, PRESCALE=1 → q stops at 0012 with done = 1 and running = 0. Further start pulses leave q = 0012. clear → q = 0, IDLE.
- Lap: in RUN, assert lap in the same cycle as a tick at q = 0042 → lap_q = 0042, lap_valid high for exactly 1 cycle, and q = 0043. lap in IDLE → no lap_valid.
- Priority/reset: clear+start+lap in one RUN cycle → IDLE, q = 0, lap_valid = 0. stop+start in RUN → PAUSE. reset asserted mid-RUN at q = 0345 → all outputs at reset values next cycle.
